// File: rtl/instr_encoder.sv
// instr_encoder: packs field-level MIPS requests into 32-bit words and streams them into imem.
// Optional ENC_CHECK_EN rejects R-type with unsupported funct or rd=0, and lw/addi with rt=0.
module instr_encoder #(
    parameter int ADDR_W    = 6,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_kind,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [5:0]        in_funct,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    input  logic              in_last,
    output logic              we,
    output logic [ADDR_W-1:0] wa,
    output logic [31:0]       wd,
    input  logic              imem_ready,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   count
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0]   FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    state_t            state_q;
    logic              we_q, done_q, err_q, last_q;
    logic [ADDR_W-1:0] wa_q;
    logic [31:0]       wd_q;
    logic [ADDR_W:0]   count_q, count_d;
    logic [5:0]        opcode;
    logic [31:0]       enc_wd;
    logic              enc_legal;

    always_comb begin
        opcode = in_kind == 3'd1 ? 6'h23 :
                 in_kind == 3'd2 ? 6'h2b :
                 in_kind == 3'd3 ? 6'h04 :
                 in_kind == 3'd4 ? 6'h08 :
                 in_kind == 3'd5 ? 6'h02 : 6'h00;
        enc_wd = in_kind == 3'd0 ? {6'h00, in_rs, in_rt, in_rd, 5'b0, in_funct} :
                 in_kind == 3'd5 ? {opcode, in_target} :
                                   {opcode, in_rs, in_rt, in_imm};
        enc_legal = in_kind < 3'd6;
`ifdef ENC_CHECK_EN
        if (in_kind == 3'd0 && (in_rd == 5'd0 ||
            !(in_funct inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2a})))
            enc_legal = 1'b0;
        if ((in_kind == 3'd1 || in_kind == 3'd4) && in_rt == 5'd0)
            enc_legal = 1'b0;
`endif
        count_d = count_q + 1'b1;
    end

    assign in_ready = (state_q == IDLE) & ~reset;
    assign we       = we_q;
    assign wa       = wa_q;
    assign wd       = wd_q;
    assign done     = done_q;
    assign err      = err_q;
    assign count    = count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            wa_q    <= BASE;
            wd_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            last_q  <= 1'b0;
            count_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    if (enc_legal) begin
                        wd_q    <= enc_wd;
                        wa_q    <= BASE + count_q[ADDR_W-1:0];
                        we_q    <= 1'b1;
                        last_q  <= in_last;
                        state_q <= WRITE;
                    end else begin
                        err_q <= 1'b1;
                        if (in_last) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                WRITE: if (imem_ready) begin
                    we_q    <= 1'b0;
                    count_q <= count_d;
                    if (last_q || count_d == FULL) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        // memory filled before the program said it was finished
                        if (!last_q) err_q <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                DONE: if (start) begin
                    state_q <= IDLE;
                    count_q <= '0;
                    err_q   <= 1'b0;
                    done_q  <= 1'b0;
                    wa_q    <= BASE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/instr_encoder.md
# instr_encoder

Sequential MIPS instruction encoder and instruction-memory loader. It is the inverse of the main control decoder: it takes field-level requests for the six supported instruction classes (R-type, lw, sw, beq, addi, j), packs them into 32-bit MIPS words, and writes them to consecutive instruction-memory addresses over a write handshake. It sits between the testbench/boot sequencer and the instruction memory of the single-cycle processor.

## Interface
- ADDR_W, 6, imem word-address width; depth DEPTH = 2^ADDR_W
- BASE_ADDR, 0, first word address written after reset/start
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  restart a new program load; honoured only in DONE
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid & in_ready
- in_kind  in  3  0 R-type, 1 lw, 2 sw, 3 beq, 4 addi, 5 j, 6/7 illegal
- in_rs, in_rt, in_rd  in  5 each  register fields
- in_funct  in  6  R-type funct
- in_imm  in  16  immediate / branch offset
- in_target  in  26  jump target
- in_last  in  1  final instruction of the program
- we  out  1  imem write request
- wa  out  ADDR_W  imem write word address
- wd  out  32  imem write data
- imem_ready  in  1  write completes on cycle with we & imem_ready
- done  out  1  load finished
- err  out  1  sticky error flag
- count  out  ADDR_W+1  words written since reset/start

## Operation
- States: IDLE, WRITE, DONE. in_ready = (state==IDLE) & ~reset.
- Encoding: R = {000000, rs, rt, rd, 00000, funct}; lw = {100011, rs, rt, imm}; sw = {101011, rs, rt, imm}; beq = {000100, rs, rt, imm}; addi = {001000, rs, rt, imm}; j = {000010, target}.
- IDLE, accept, legal kind: register wd, wa = (BASE_ADDR + count) mod DEPTH, we=1, latch last flag, go WRITE.
- IDLE, accept, illegal kind: err=1, no write, count unchanged; go DONE if in_last, else stay IDLE.
- WRITE: hold we/wa/wd stable while imem_ready=0. On we & imem_ready: we=0, count+1; go DONE if latched last or count reaches DEPTH; else IDLE.
- Count reaching DEPTH without last set: err=1. Address wraps DEPTH-1 -> 0 when BASE_ADDR ≠ 0.
- DONE: done=1, in_ready=0. start=1 -> IDLE next cycle, count=0, err=0, done=0. start is ignored outside DONE.

## Timing
- Reset values: state IDLE, we=0, wa=BASE_ADDR, wd=0, done=0, err=0, count=0; in_ready=0 while reset is high.
- Accept at edge N -> we=1 with valid wa/wd from cycle N+1. Best-case throughput: one word per 2 cycles.
- in_ready is 0 for the whole of WRITE; requests are never buffered.
- Reset mid-WRITE: the pending word is dropped; no write completes after the reset edge.
- Reset has priority over start and over all handshakes.

## Configuration
- ENC_CHECK_EN defined: additional illegal cases, handled exactly like kinds 6/7 (err=1, not written):
  - R-type with funct not in {0x20, 0x22, 0x24, 0x25, 0x2A};
  - R-type with rd=0;
  - lw/addi with rt=0.
- ENC_CHECK_EN undefined: only kinds 6/7 are illegal; all other fields are encoded verbatim.

## Test plan
- Reset, then addi kind=4, rs=0, rt=8, imm=5 -> next cycle we=1, wa=0, wd=0x20080005; with imem_ready=1, count=1 and in_ready=1 one cycle later.
- R add rs=8, rt=9, rd=10, funct=0x20, imem_ready low 3 cycles -> wd=0x01095020, we/wa/wd stable and in_ready=0 for all 3 cycles, completes on the 4th.
- Sequence: lw rs=8, rt=9, imm=4 -> 0x8D090004; sw same fields -> 0xAD090004; beq imm=0xFFFE -> 0x1109FFFE; j target=0x10 with in_last -> 0x08000010 at wa=3, then done=1, in_ready=0.
- kind=6 without last -> no we, err=1, count unchanged, state stays IDLE. In DONE, start=1 -> err=0, count=0, wa=BASE_ADDR.
- ADDR_W=2, BASE_ADDR=2, four legal writes -> wa = 2, 3, 0, 1, then DONE. err=0 if the 4th has in_last, else err=1.
- R-type funct=0x08 -> with ENC_CHECK_EN: err=1, no write. Without: wd ends in 0x08 and is written. Reset asserted during WRITE -> we=0 next cycle, count=0.
